score_digits: RTL

Holds the game score as a saturating binary counter and, once per video frame, converts a snapshot of it to decimal digits with a sequential double-dabble converter. It sits directly upstream of the per-digit glyph renderers. Each renderer takes one 4-bit digit value plus a screen position. Digits change only once per frame, so a digit never changes partway through a scan.

---
 rtl/score_pkg.sv | 19 +
 rtl/bcd_adjust.sv | 10 +
 rtl/score_digits.sv | 117 +++++++++++
 3 files changed

// File: rtl/score_pkg.sv
// Shared types and sizing helpers for the score-to-decimal display path.
// Pure declarations; no timing or flow control.
package score_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} conv_state_t;

    localparam int DIGITS_DEF = 4;
    localparam int WIDTH_DEF  = 14;

    function automatic int max_score(input int digits);
        int m;
        m = 1;
        for (int i = 0; i < digits; i++) begin
            m = m * 10;
        end
        return m - 1;
    endfunction

endpackage

// File: rtl/bcd_adjust.sv
// One double-dabble nibble correction: add 3 when the nibble is 5 or more.
// Combinational, zero latency, no flow control.
module bcd_adjust (
    input  logic [3:0] i_nib,
    output logic [3:0] o_nib
);

    assign o_nib = (i_nib >= 4'd5) ? i_nib + 4'd3 : i_nib;

endmodule

// File: rtl/score_digits.sv
// Saturating score counter with a once-per-frame sequential binary-to-BCD converter.
// New digits appear WIDTH+1 cycles after frame; frames arriving while busy are dropped.
module score_digits
    import score_pkg::*;
#(
    parameter int DIGITS = DIGITS_DEF,
    parameter int WIDTH  = WIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                score_inc,
    input  logic                score_clr,
    input  logic                frame,
    output logic [DIGITS*4-1:0] digits,
    output logic [DIGITS-1:0]   digit_en,
    output logic                busy
);

    localparam int                NB   = DIGITS * 4;
    localparam int                CW   = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0]  MAX  = WIDTH'(max_score(DIGITS));
    localparam logic [CW-1:0]     LAST = CW'(WIDTH - 1);

    conv_state_t       r_state;
    conv_state_t       w_state_nxt;
    logic [WIDTH-1:0]  r_score;
    logic [WIDTH-1:0]  r_snap;
    logic [NB-1:0]     r_bcd;
    logic [CW-1:0]     r_cnt;
    logic [NB-1:0]     r_digits;
    logic [DIGITS-1:0] r_digit_en;
    logic [NB-1:0]     w_bcd_adj;
    logic [DIGITS-1:0] w_en;
    logic              w_any;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_adjust u_adj (
            .i_nib (r_bcd[4*g +: 4]),
            .o_nib (w_bcd_adj[4*g +: 4])
        );
    end

    // Clear beats increment; the counter sticks at MAX instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_score <= '0;
        end else if (score_clr) begin
            r_score <= '0;
        end else if (score_inc && (r_score != MAX)) begin
            r_score <= r_score + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (frame) w_state_nxt = SHIFT;
            SHIFT:   if (r_cnt == LAST) w_state_nxt = LOAD;
            LOAD:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // A digit is drawn if it or any more significant digit is nonzero.
    always_comb begin
        w_en  = '0;
        w_any = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_any   = w_any | (|r_bcd[4*i +: 4]);
            w_en[i] = w_any;
        end
        w_en[0] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_snap     <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_digits   <= '0;
            r_digit_en <= DIGITS'(1);
        end else begin
            case (r_state)
                IDLE: begin
                    if (frame) begin
                        r_snap <= r_score;
                        r_bcd  <= '0;
                        r_cnt  <= '0;
                    end
                end
                SHIFT: begin
                    r_bcd  <= {w_bcd_adj[NB-2:0], r_snap[WIDTH-1]};
                    r_snap <= {r_snap[WIDTH-2:0], 1'b0};
                    r_cnt  <= r_cnt + 1'b1;
                end
                LOAD: begin
                    r_digits   <= r_bcd;
                    r_digit_en <= w_en;
                end
                default: ;
            endcase
        end
    end

    assign digits   = r_digits;
    assign digit_en = r_digit_en;
    assign busy     = (r_state != IDLE);

endmodule
